// File: rtl/spi_seq_pkg.sv
// Shared encodings and constants for the SPI transfer sequencer.
package spi_seq_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_ISSUE   = 3'd3;
  localparam logic [2:0] S_WAIT_LO = 3'd4;
  localparam logic [2:0] S_WAIT_HI = 3'd5;
  localparam logic [2:0] S_PUSH    = 3'd6;
  localparam logic [2:0] S_HOLD    = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_SETUP   = S_SETUP,
    ST_FETCH   = S_FETCH,
    ST_ISSUE   = S_ISSUE,
    ST_WAIT_LO = S_WAIT_LO,
    ST_WAIT_HI = S_WAIT_HI,
    ST_PUSH    = S_PUSH,
    ST_HOLD    = S_HOLD
  } state_t;

  // Cycles core_done may stay high after a write before the engine is declared stuck.
  localparam int TO_LIMIT = 4;
  localparam int TO_W     = 3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_seq_tmr.sv
// Loadable down-counter with zero flag; times the ss_n setup and hold gaps.
module spi_seq_tmr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/spi_xfer_seq.sv
// Burst sequencer in front of the SPI byte engine: one word per engine write, framed by ss_n.
// SPI_XFER_SEQ_TIMEOUT_EN adds a stuck-engine timeout with a sticky err flag.
module spi_xfer_seq
  import spi_seq_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int LEN_W    = 8,
  parameter int SS_SETUP = 2,
  parameter int SS_HOLD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DWIDTH-1:0] tx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [DWIDTH-1:0] rx_data,
  output logic              core_cs,
  output logic              core_wr,
  output logic              core_rd,
  output logic [DWIDTH-1:0] core_din,
  input  logic [DWIDTH-1:0] core_dout,
  input  logic              core_done,
  output logic              ss_n,
  output logic              busy,
  output logic              err
);

  localparam int TMR_W = $clog2(max2(SS_SETUP, SS_HOLD)) + 1;
  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SS_SETUP - 1);
  localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(SS_HOLD - 1);

  if (SS_SETUP < 1) begin : g_bad_setup
    $error("SS_SETUP must be at least 1");
  end
  if (SS_HOLD < 1) begin : g_bad_hold
    $error("SS_HOLD must be at least 1");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_idle_q;
  logic              r_ss_n;
  logic              r_rx_valid;
  logic [DWIDTH-1:0] r_rx_data;
  logic              r_core_cs;
  logic              r_core_wr;
  logic [DWIDTH-1:0] r_core_din;
  logic [LEN_W-1:0]  r_remaining;

  logic              w_tmr_load;
  logic              w_tmr_dec;
  logic [TMR_W-1:0]  w_tmr_val;
  logic              w_tmr_zero;
  logic              w_accept;
  logic              w_tx_hs;
  logic              w_rx_hs;
  logic              w_last;
  logic              w_capture;
  logic              w_timeout;

  // r_idle_q delays cmd_ready one cycle after returning to IDLE so ss_n sees a high gap.
  assign cmd_ready = (r_state == ST_IDLE) && r_idle_q;
  assign tx_ready  = (r_state == ST_FETCH) && core_done;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_tx_hs   = tx_valid && tx_ready;
  assign w_rx_hs   = r_rx_valid && rx_ready;
  assign w_last    = (r_remaining == '0);
  assign w_capture = (r_state == ST_WAIT_HI) && core_done;

`ifdef SPI_XFER_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;

  assign w_timeout = (r_state == ST_WAIT_LO) && core_done && (r_to_cnt == TO_W'(TO_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if ((r_state == ST_WAIT_LO) && core_done && !w_timeout) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  spi_seq_tmr #(
    .W(TMR_W)
  ) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_tmr_load),
    .i_dec  (w_tmr_dec),
    .i_val  (w_tmr_val),
    .o_zero (w_tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_dec   = 1'b0;
    w_tmr_val   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SETUP;
          w_tmr_load  = 1'b1;
          w_tmr_val   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      ST_FETCH: begin
        if (w_tx_hs) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!core_done) begin
          w_state_nxt = ST_WAIT_HI;
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_HI: begin
        if (core_done) begin
          w_state_nxt = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (w_rx_hs) begin
          if (w_last) begin
            w_state_nxt = ST_HOLD;
            w_tmr_load  = 1'b1;
            w_tmr_val   = HOLD_LD;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_HOLD: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_q    <= 1'b0;
      r_ss_n      <= 1'b1;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= '0;
      r_core_cs   <= 1'b0;
      r_core_wr   <= 1'b0;
      r_core_din  <= '0;
      r_remaining <= '0;
    end else begin
      r_idle_q <= (r_state == ST_IDLE);

      if (w_accept) begin
        r_remaining <= cmd_len;
        r_ss_n      <= 1'b0;
      end else if ((r_state == ST_HOLD && w_tmr_zero) || w_timeout) begin
        r_ss_n <= 1'b1;
      end

      if (w_tx_hs) begin
        r_core_din <= tx_data;
        r_core_cs  <= 1'b1;
        r_core_wr  <= 1'b1;
      end else if (r_state == ST_ISSUE) begin
        r_core_cs <= 1'b0;
        r_core_wr <= 1'b0;
      end

      // The next word is only fetched once the current RX word has been taken.
      if (w_capture) begin
        r_rx_data  <= core_dout;
        r_rx_valid <= 1'b1;
      end else if (w_rx_hs) begin
        r_rx_valid <= 1'b0;
        if (!w_last) begin
          r_remaining <= r_remaining - 1'b1;
        end
      end
    end
  end

  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign core_cs  = r_core_cs;
  assign core_wr  = r_core_wr;
  assign core_rd  = 1'b0;
  assign core_din = r_core_din;
  assign ss_n     = r_ss_n;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: doc/spi_xfer_seq.md
Name: spi_xfer_seq

Overview:
Transaction sequencer directly upstream of the SPI byte engine (spi_core, CPOL=0/CPHA=1 engine). Accepts a burst command (word count) plus a TX word stream from the host. Drives the engine's cs/wr/din one word at a time and qualifies completion on its done/dout. Returns the RX words as a stream and frames the burst with an active-low slave-select, with setup/hold spacing.

Parameters:
DWIDTH, 8, word width; equal to the engine's DWIDTH
LEN_W, 8, command length field width
SS_SETUP, 2, clk cycles ss_n is low before the first word is issued (>=1)
SS_HOLD, 2, clk cycles ss_n stays low after the last word completes (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  burst request
cmd_ready  out  1  high only in IDLE
cmd_len  in  LEN_W  burst length minus one (0 means 1 word, max 2^LEN_W words)
tx_valid  in  1  TX word available
tx_ready  out  1  TX word consumed this cycle
tx_data  in  DWIDTH  TX word
rx_valid  out  1  RX word available
rx_ready  in  1  RX consumer accepts
rx_data  out  DWIDTH  RX word
core_cs  out  1  to engine cs
core_wr  out  1  to engine wr, one-cycle pulse
core_rd  out  1  to engine rd, tied 0
core_din  out  DWIDTH  to engine din
core_dout  in  DWIDTH  from engine dout
core_done  in  1  from engine done (high = idle, result valid)
ss_n  out  1  slave select, active low
busy  out  1  high in every state except IDLE
err  out  1  sticky timeout flag (see Optional Feature)

Behaviour:
- Reset values: ss_n=1, cmd_ready=0 during reset then 1 in IDLE, tx_ready=0, rx_valid=0, rx_data=0, core_cs=0, core_wr=0, core_din=0, busy=0, err=0. State=IDLE, counters=0.
- Reset is asynchronous and may arrive mid-burst. Outputs return to reset values immediately. The burst is abandoned and no RX word is emitted.
- IDLE:
  - On cmd_valid & cmd_ready: latch remaining=cmd_len; load timer=SS_SETUP-1; ss_n<=0; go to SETUP.
- SETUP:
  - Count timer down; at 0 go to FETCH.
- FETCH:
  - tx_ready=1 combinationally only when core_done=1.
  - On tx_valid & tx_ready: core_din<=tx_data, core_cs<=1, core_wr<=1; go to ISSUE.
- ISSUE (1 cycle, wr pulse seen by engine):
  - Next cycle core_wr<=0, core_cs<=0; go to WAIT_LO.
- WAIT_LO:
  - Wait for core_done=0, i.e. engine accepted. Then go to WAIT_HI.
- WAIT_HI:
  - Wait for core_done=1.
  - Same edge: rx_data<=core_dout, rx_valid<=1; go to PUSH.
- PUSH:
  - Hold rx_valid/rx_data stable until rx_ready.
  - On handshake, rx_valid<=0.
  - If remaining==0: timer=SS_HOLD-1, go to HOLD. Else remaining<=remaining-1, go to FETCH.
  - RX backpressure stalls the burst. The next word is not issued until the current RX word is taken.
- HOLD:
  - Count down; at 0: ss_n<=1, go to IDLE.
  - cmd_ready returns one cycle after ss_n deasserts, giving a minimum 1-cycle ss_n-high gap between bursts.
- cmd_valid outside IDLE is ignored; cmd_len is sampled only at acceptance.
- Word count arithmetic is LEN_W bits with no wrap. cmd_len=2^LEN_W-1 yields exactly 2^LEN_W words.
- Minimum per-word latency, tx handshake to rx_valid: 3 cycles plus engine time (2*DWIDTH*5 clk).

Optional Feature:
SPI_XFER_SEQ_TIMEOUT_EN
- Defined:
  - A 3-bit counter runs in WAIT_LO. If core_done stays 1 for 4 cycles, set err (sticky until rst).
  - ss_n<=1, drop the burst (no rx_valid), go to IDLE.
- Undefined: no counter; WAIT_LO waits indefinitely; err tied 0.

Decomposition:
- spi_seq_pkg holds:
  - state encodings as localparams: IDLE, SETUP, FETCH, ISSUE, WAIT_LO, WAIT_HI, PUSH, HOLD (3 bits)
  - the timeout limit constant (4).
- One natural sub-module: spi_seq_tmr, a loadable down-counter with zero flag, shared by SETUP and HOLD. Width is $clog2(max(SS_SETUP,SS_HOLD))+1.

Test Plan:
- Single word: cmd_len=0, tx_data=8'hA5, slave echoes 8'h3C on miso.
  - Expect ss_n low 2 cycles before core_wr.
  - Expect one core_wr pulse with core_din=8'hA5.
  - Expect rx_data=8'h3C, one rx_valid.
  - Expect ss_n high 2 cycles after rx handshake.
- Burst: cmd_len=3, tx 8'h01,02,03,04, loopback miso=mosi.
  - Expect 4 wr pulses and RX 8'h01..04 in order.
  - Expect ss_n low continuously for the whole burst.
- Backpressure: cmd_len=1, rx_ready held 0 for 50 cycles after first rx_valid.
  - Expect rx_data stable, no second core_wr until rx_ready=1, then second word completes.
- TX starvation: tx_valid low 20 cycles in FETCH.
  - Expect ss_n remains low, no core_wr, busy=1.
  - Expect the burst resumes when tx_valid rises.
- Mid-burst reset: assert rst during WAIT_HI of word 2 of 4.
  - Expect immediate ss_n=1, rx_valid=0, busy=0.
  - A new cmd_len=0 burst afterwards completes normally.
- Timeout (macro defined): hold core_done=1 stuck.
  - Expect err=1 four cycles after entering WAIT_LO, ss_n=1, cmd_ready=1.
- Timeout (macro undefined): same stimulus.
  - Expect busy stays 1 and err=0.
